// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin sequencer sharing one AES-256 core among NUM_REQ requesters
module aes_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [128*NUM_REQ-1:0]   req_plaintext,
    input  logic [256*NUM_REQ-1:0]   req_key,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [127:0]             resp_ciphertext,
    output logic                     resp_error,
    output logic                     core_start,
    output logic [127:0]             core_plaintext,
    output logic [255:0]             core_key,
    input  logic [127:0]             core_ciphertext,
    input  logic                     core_done
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, ACCEPT, START, WAIT, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] g;
    logic            armed;
    logic [CNT_W-1:0] wd_cnt;

    logic [ID_W-1:0] sel;
    logic            sel_found;
    logic [ID_W:0]   sum;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            if (req_valid[sum[ID_W-1:0]]) begin
                sel       = sum[ID_W-1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            g               <= '0;
            armed           <= 1'b0;
            wd_cnt          <= '0;
            req_ready       <= '0;
            resp_valid      <= 1'b0;
            resp_id         <= '0;
            resp_ciphertext <= '0;
            resp_error      <= 1'b0;
            core_start      <= 1'b0;
            core_plaintext  <= '0;
            core_key        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        g         <= sel;
                        req_ready <= NUM_REQ'(1) << sel;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    req_ready      <= '0;
                    core_plaintext <= req_plaintext[128*g +: 128];
                    core_key       <= req_key[256*g +: 256];
                    resp_id        <= g;
                    core_start     <= 1'b1;
                    state          <= START;
                end
                START: begin
                    core_start <= 1'b0;
                    armed      <= 1'b0;
                    wd_cnt     <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // armed ignores a done level left over from the previous operation
                    if (armed && core_done) begin
                        resp_ciphertext <= core_ciphertext;
                        resp_error      <= 1'b0;
                        resp_valid      <= 1'b1;
                        state           <= RESP;
                    end else begin
                        if (!core_done) begin
                            armed <= 1'b1;
                        end
                        if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                            resp_ciphertext <= '0;
                            resp_error      <= 1'b1;
                            resp_valid      <= 1'b1;
                            state           <= RESP;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - self-checking bench for aes_core_arbiter with core model and scoreboard
module tb_aes_core_arbiter;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int TMO = 15;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid, req_ready;
    logic [128*N-1:0]  req_plaintext;
    logic [256*N-1:0]  req_key;
    logic              resp_valid, resp_ready, resp_error, core_start, core_done;
    logic [IW-1:0]     resp_id;
    logic [127:0]      resp_ciphertext, core_plaintext, core_ciphertext;
    logic [255:0]      core_key;

    aes_core_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_plaintext(req_plaintext), .req_key(req_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_ciphertext(resp_ciphertext), .resp_error(resp_error),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_ciphertext(core_ciphertext), .core_done(core_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the AES core: the known vector maps to its real ciphertext, everything else to a fixed mix.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return {pt[119:0], pt[127:120]} ^ key[127:0] ^ key[255:128] ^ 128'hc3;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Requesters: valid is high while issued requests outnumber granted ones.
    logic [127:0] pt_r  [N];
    logic [255:0] key_r [N];
    int issue_cnt [N];
    int done_cnt  [N];
    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign req_plaintext[128*gi +: 128] = pt_r[gi];
        assign req_key[256*gi +: 256]       = key_r[gi];
        assign req_valid[gi]                = (issue_cnt[gi] != done_cnt[gi]);
    end

    int core_lat   = 14;
    bit rand_lat   = 1'b0;
    bit level_mode = 1'b0;
    bit core_hang  = 1'b0;
    int rr_mode    = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [127:0]  ct;
        logic          err;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int grant_log[$];
    int model_rr = 0, grants = 0, starts = 0, resps = 0;
    int busy_cnt = 0, clear_cnt = 0;
    int start_cyc = 0, qual_cyc = -1, rv_cyc = 0, last_ready_cyc = 0;
    int m_g, m_eg;
    bit low_seen = 1'b0, prev_hold = 1'b0, prev_rv = 1'b0;
    logic [N-1:0]  mask_prev = '0, drop_pending = '0;
    logic [127:0]  cur_pt, h_ct, last_ct;
    logic [255:0]  cur_key;
    logic [IW-1:0] h_id, last_id;
    logic          h_err, last_err;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_rr     = 0;
            drop_pending = '0;
            busy_cnt     = 0;
            clear_cnt    = 0;
            core_done    = 1'b0;
            core_ciphertext = '0;
            resp_ready   = 1'b0;
            prev_hold    = 1'b0;
            prev_rv      = 1'b0;
            mask_prev    = '0;
        end else begin
            mask_prev = req_valid;
            if (core_start) begin
                starts++;
                chk("one_start_per_grant", starts, grants);
                cur_pt   = core_plaintext;
                cur_key  = core_key;
                busy_cnt = rand_lat ? $urandom_range(4, 12) : core_lat;
                if (level_mode) clear_cnt = 2;
                else core_done = 1'b0;
                start_cyc = cyc;
                low_seen  = 1'b0;
                qual_cyc  = -1;
            end else begin
                if (clear_cnt > 0) begin
                    clear_cnt--;
                    if (clear_cnt == 0) core_done = 1'b0;
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0 && !core_hang) begin
                        core_done       = 1'b1;
                        core_ciphertext = aes_ref(cur_pt, cur_key);
                    end
                end else if (!level_mode) begin
                    core_done = 1'b0;
                end
            end
            // A done only qualifies after a low done has been seen since the start pulse.
            if (cyc > start_cyc) begin
                if (core_done && low_seen && qual_cyc < 0) qual_cyc = cyc;
                if (!core_done) low_seen = 1'b1;
            end

            if (req_ready != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                m_g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) m_g = i;
                m_eg = -1;
                for (int k = N - 1; k >= 0; k--) if (mask_prev[(model_rr + k) % N]) m_eg = (model_rr + k) % N;
                chk("grant_order", m_g, m_eg);
                grants++;
                last_ready_cyc = cyc;
                grant_log.push_back(m_g);
                exp_q.push_back('{id: IW'(m_g), ct: core_hang ? 128'h0 : aes_ref(pt_r[m_g], key_r[m_g]), err: core_hang});
                drop_pending = req_ready;
            end else if (drop_pending != '0) begin
                for (int i = 0; i < N; i++) if (drop_pending[i]) done_cnt[i]++;
                drop_pending = '0;
            end

            case (rr_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'($urandom_range(0, 1));
                default: resp_ready = 1'b0;
            endcase
            if (prev_hold) begin
                chk("hold_valid", resp_valid, 1);
                chk("hold_id", resp_id, h_id);
                chk("hold_ct", resp_ciphertext, h_ct);
                chk("hold_err", resp_error, h_err);
            end
            if (resp_valid && !prev_rv) begin
                rv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_id %0d, expected no response", resp_id);
                end else if (exp_q[0].err) begin
                    chk("timeout_latency", rv_cyc - start_cyc, TMO + 1);
                end else begin
                    chk("done_latency", rv_cyc, qual_cyc + 1);
                end
            end
            if (resp_valid && resp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_id", resp_id, e.id);
                chk("resp_ct", resp_ciphertext, e.ct);
                chk("resp_err", resp_error, e.err);
                model_rr = (int'(e.id) + 1) % N;
                last_id  = resp_id;
                last_ct  = resp_ciphertext;
                last_err = resp_error;
                resps++;
            end
            prev_hold = resp_valid && !resp_ready;
            prev_rv   = resp_valid;
            h_id      = resp_id;
            h_ct      = resp_ciphertext;
            h_err     = resp_error;
        end
    end

    typedef struct {
        logic [N-1:0] mask;
        int           first;
        int           last;
    } vec_t;
    vec_t vecs[7];

    task automatic issue(input int i, input logic [127:0] pt, input logic [255:0] key);
        pt_r[i]  = pt;
        key_r[i] = key;
        issue_cnt[i]++;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        @(posedge clk); #1;
        while ((req_valid != '0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, (req_valid == '0 && exp_q.size() == 0), 1);
    endtask

    task automatic wait_resp_valid(input string name, input int budget);
        int n = 0;
        while (!resp_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_resp_seen"}, resp_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_ct"}, resp_ciphertext, 0);
        chk({tag, "_resp_err"}, resp_error, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_pt"}, core_plaintext, 0);
        chk({tag, "_core_key"}, core_key, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    int c0, g0, s0, r0, base, n;

    initial begin
        for (int i = 0; i < N; i++) begin
            pt_r[i]  = '0;
            key_r[i] = '0;
        end
        vecs[0] = '{4'b0100, 2, 2};
        vecs[1] = '{4'b0011, 0, 1};
        vecs[2] = '{4'b1001, 3, 0};
        vecs[3] = '{4'b1010, 1, 3};
        vecs[4] = '{4'b0110, 1, 2};
        vecs[5] = '{4'b0101, 0, 2};
        vecs[6] = '{4'b1000, 3, 3};

        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;

        // Single known-answer request on requester 2
        core_lat = 14;
        c0 = cyc; g0 = grants; s0 = starts;
        issue(2, FIPS_PT, FIPS_KEY);
        wait_drain("t1", 100);
        chk("t1_grants", grants - g0, 1);
        chk("t1_starts", starts - s0, 1);
        chk("t1_ready_cycle", last_ready_cyc, c0 + 1);
        chk("t1_start_cycle", start_cyc, c0 + 2);
        chk("t1_resp_cycle", rv_cyc, c0 + 2 + 14 + 1);
        chk("t1_id", last_id, 2);
        chk("t1_ct", last_ct, FIPS_CT);
        chk("t1_err", last_err, 0);

        // All four requesters held high for eight grants
        do_reset();
        core_lat = 6;
        base = grant_log.size();
        for (int i = 0; i < N; i++) begin
            issue(i, rnd128(), {rnd128(), rnd128()});
            issue_cnt[i]++;
        end
        wait_drain("t2", 400);
        chk("t2_count", grant_log.size() - base, 8);
        if (grant_log.size() - base >= 8)
            for (int k = 0; k < 8; k++) chk("t2_order", grant_log[base + k], k % N);

        // Level-held done with back-to-back requests 0 then 1
        do_reset();
        level_mode = 1'b1;
        core_lat = 6;
        base = grant_log.size();
        issue(0, rnd128(), {rnd128(), rnd128()});
        issue(1, rnd128(), {rnd128(), rnd128()});
        wait_drain("t3", 200);
        chk("t3_count", grant_log.size() - base, 2);
        if (grant_log.size() - base >= 2) begin
            chk("t3_first", grant_log[base], 0);
            chk("t3_second", grant_log[base + 1], 1);
        end
        level_mode = 1'b0;

        // Response back-pressure for 20 cycles with another request waiting
        do_reset();
        core_lat = 8;
        rr_mode = 2;
        issue(1, rnd128(), {rnd128(), rnd128()});
        wait_resp_valid("t4", 100);
        issue(3, rnd128(), {rnd128(), rnd128()});
        g0 = grants; s0 = starts;
        repeat (20) @(posedge clk);
        #1;
        chk("t4_no_grant", grants, g0);
        chk("t4_no_start", starts, s0);
        chk("t4_still_valid", resp_valid, 1);
        rr_mode = 0;
        wait_drain("t4", 200);
        chk("t4_next_grant", grant_log[grant_log.size() - 1], 3);

        // Hung core trips the watchdog, then a normal request follows
        core_hang = 1'b1;
        issue(1, rnd128(), {rnd128(), rnd128()});
        wait_resp_valid("t5", 100);
        chk("t5_err", resp_error, 1);
        chk("t5_ct", resp_ciphertext, 0);
        wait_drain("t5", 100);
        core_hang = 1'b0;
        issue(2, rnd128(), {rnd128(), rnd128()});
        wait_drain("t5b", 100);
        chk("t5b_err", last_err, 0);
        chk("t5b_id", last_id, 2);

        // Reset while the core is busy aborts the operation
        core_lat = 14;
        s0 = starts;
        issue(1, rnd128(), {rnd128(), rnd128()});
        n = 0;
        while (starts == s0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_started", starts - s0, 1);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk); #3 reset = 1'b0;
        r0 = resps;
        @(posedge clk); #1;
        issue(3, rnd128(), {rnd128(), rnd128()});
        wait_drain("t6", 100);
        chk("t6_one_resp", resps - r0, 1);
        chk("t6_grant", grant_log[grant_log.size() - 1], 3);
        chk("t6_id", last_id, 3);

        // Table of request masks applied from a fresh reset
        do_reset();
        core_lat = 5;
        for (int v = 0; v < 7; v++) begin
            base = grant_log.size();
            for (int i = 0; i < N; i++) if (vecs[v].mask[i]) issue(i, rnd128(), {rnd128(), rnd128()});
            wait_drain("vec", 300);
            chk("vec_count", grant_log.size() - base, $countones(vecs[v].mask));
            if (grant_log.size() > base) begin
                chk("vec_first", grant_log[base], vecs[v].first);
                chk("vec_last", grant_log[grant_log.size() - 1], vecs[v].last);
            end
        end

        // Random traffic, pulse then level-held done
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            level_mode = 1'(ph);
            rand_lat = 1'b1;
            rr_mode = 1;
            for (int t = 0; t < 600; t++) begin
                @(posedge clk); #1;
                for (int i = 0; i < N; i++)
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) issue(i, rnd128(), {rnd128(), rnd128()});
            end
            wait_drain("rand", 1000);
        end
        rand_lat = 1'b0;
        level_mode = 1'b0;
        rr_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AES-256 encrypt core (start/done handshake, 128-bit block, 256-bit key) among NUM_REQ independent requesters.
- Accepts one request at a time, drives the core start pulse, waits for completion and returns the ciphertext on a single tagged response channel with valid/ready flow control.
- Includes a watchdog so a hung core cannot lock the shared resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of resp_id; must satisfy 2^ID_W >= NUM_REQ.
- TIMEOUT, 1023, max cycles spent in WAIT before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high, for one cycle.
- req_plaintext  in  128*NUM_REQ  plaintext, requester i in bits [128*i +: 128].
- req_key  in  256*NUM_REQ  key, requester i in bits [256*i +: 256].
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester this response belongs to.
- resp_ciphertext  out  128  ciphertext; all-zero when resp_error=1.
- resp_error  out  1  watchdog expired for this request.
- core_start  out  1  one-cycle start pulse to the core.
- core_plaintext  out  128  registered plaintext to the core.
- core_key  out  256  registered key to the core.
- core_ciphertext  in  128  core result.
- core_done  in  1  core completion; pulse or level-held (both supported).

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_valid, resp_id, resp_ciphertext, resp_error, core_start, core_plaintext, core_key). Reset during any state aborts the in-flight operation and drops any pending response; no response is produced for it.
- FSM states: IDLE, ACCEPT, START, WAIT, RESP.
- IDLE: if any req_valid, select the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register grant index g; go to ACCEPT.
- ACCEPT (1 cycle): req_ready[g]=1. Latch req_plaintext[g] into core_plaintext and req_key[g] into core_key. Latch g as resp_id. Go to START.
  - Requester contract: hold valid and data stable from the assertion of valid until the cycle in which ready=1.
- START (1 cycle): core_start=1; clear the armed flag and the watchdog counter; go to WAIT. core_plaintext/core_key hold until the next ACCEPT.
- WAIT: core_start=0.
  - armed is set in any cycle where core_done=0.
  - Completion = armed && core_done. This ignores a stale level-held done from the previous operation.
  - On completion: resp_ciphertext=core_ciphertext, resp_error=0, resp_valid=1; go to RESP.
  - Watchdog: counter increments each WAIT cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT before completion: resp_ciphertext=0, resp_error=1, resp_valid=1; go to RESP.
- RESP: outputs held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: resp_valid=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - core_done activity in RESP is ignored.
- Latency: request seen in IDLE at cycle 0 -> ready at cycle 1 -> core_start at cycle 2 -> resp_valid one cycle after qualified done. Minimum idle gap between grants is 1 cycle (the IDLE state).
- Fairness: a requester holding valid is granted within NUM_REQ grants. The same requester is never granted twice in a row while another is valid.
- Requests arriving outside IDLE wait; no queuing beyond the requesters' own valid hold.

Test Plan:
- Single request on req 2: plaintext 00112233445566778899aabbccddeeff, key 000102...1f (32 bytes), core model 14-cycle latency -> req_ready[2] one pulse, exactly one core_start, resp_id=2, resp_ciphertext=8ea2b7ca516745bfeafc49904b496089, resp_error=0.
- All 4 req_valid held high, 8 requests total -> grant order 0,1,2,3,0,1,2,3; each resp_id matches its grant; exactly one core_start per grant.
- Level-held core_done (stays high until next start) with back-to-back requests 0 then 1 -> second response is not produced early; it waits for done to drop and rise again; both ciphertexts correct.
- resp_ready held low 20 cycles after resp_valid -> resp_* stable all 20 cycles, no new req_ready, no core_start; release -> IDLE, next grant proceeds.
- TIMEOUT=15, core never asserts done -> resp_valid after 15 WAIT cycles with resp_error=1 and resp_ciphertext=0; next request is served normally.
- Assert reset for 1 cycle during WAIT -> all outputs 0 asynchronously, no response for the aborted request; after release, a new request on req 3 is granted first (rr_ptr=0 scan) and completes correctly.
